// File: rtl/flag_pipeline.sv
// flag_pipeline: carries EX condition flags through MEM/WB, commits Z/V/N at WB and feeds bypassed flags to ID.
module flag_pipeline (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pipe_en,
  input  logic       EX_flush,
  input  logic       EX_valid,
  input  logic [3:0] EX_opcode,
  input  logic       EX_zero,
  input  logic       EX_ovfl,
  input  logic       EX_sign,
  input  logic       FLAG_bypass_zero,
  input  logic       FLAG_bypass_ovfl,
  input  logic       FLAG_bypass_sign,
  output logic       flag_z,
  output logic       flag_v,
  output logic       flag_n,
  output logic       branch_zero,
  output logic       branch_ovfl,
  output logic       branch_sign,
  output logic       halted
);
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_HLT = 4'hF;
  logic       mem_valid, wb_valid;
  logic [3:0] mem_op, wb_op;
  logic [2:0] mem_f, wb_f;
  logic       wr_z, wr_vn;
  // Z is written by ADD/SUB/XOR/SLL/SRA/ROR (opcodes 0-6 except 3); V/N by ADD/SUB only
  always_comb begin
    wr_z  = wb_valid && !halted && (wb_op < 4'd7) && (wb_op != 4'd3);
    wr_vn = wb_valid && !halted && (wb_op == OP_ADD || wb_op == OP_SUB);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid <= 1'b0;
      mem_op    <= '0;
      mem_f     <= '0;
      wb_valid  <= 1'b0;
      wb_op     <= '0;
      wb_f      <= '0;
    end else if (pipe_en) begin
      mem_valid <= EX_flush ? 1'b0 : EX_valid;
      mem_op    <= EX_opcode;
      mem_f     <= {EX_zero, EX_ovfl, EX_sign};
      wb_valid  <= mem_valid;
      wb_op     <= mem_op;
      wb_f      <= mem_f;
    end
  end
  // commit runs regardless of pipe_en; a stalled setter simply rewrites the same values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
      halted <= 1'b0;
    end else begin
      flag_z <= wr_z ? wb_f[2] : flag_z;
      flag_v <= wr_vn ? wb_f[1] : flag_v;
      flag_n <= wr_vn ? wb_f[0] : flag_n;
      halted <= halted || (wb_valid && wb_op == OP_HLT);
    end
  end
  assign branch_zero = FLAG_bypass_zero ? wb_f[2] : flag_z;
  assign branch_ovfl = FLAG_bypass_ovfl ? wb_f[1] : flag_v;
  assign branch_sign = FLAG_bypass_sign ? wb_f[0] : flag_n;
endmodule
